dpll_phase_detect: RTL and testbench
====================================

DPLL_PHASE_DETECT -- requirements
Module: dpll_phase_detect

Interface
REQ-001 SHALL have parameter FILT_N, default 8: random-walk filter threshold, 2..127.
REQ-002 SHALL have parameter CMD_LEN, default 2: correction pulse length in clk32_i cycles, 1..15.
REQ-003 SHALL have parameter LOCK_CNT, default 64: consecutive command-free data edges required for lock, 1..255.
REQ-004 SHALL have port clk32_i, input, 1 bit: single system clock, the 32x bit-rate clock.
REQ-005 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port data_i, input, 1 bit: demodulated DPSK bitstream, asynchronous to clk32_i.
REQ-007 SHALL have port clk_i_i, input, 1 bit: recovered in-phase bit clock from the controlled divider, synchronous to clk32_i.
REQ-008 SHALL have port pd_before_o, output, 1 bit: local clock early, delete-pulse command to the divider.
REQ-009 SHALL have port pd_after_o, output, 1 bit: local clock late, add-pulse command to the divider.
REQ-010 SHALL have port edge_o, output, 1 bit: one-cycle strobe for each detected data transition.
REQ-011 SHALL have port lock_o, output, 1 bit: loop-locked indicator.

Function
REQ-012 SHALL pass data_i through two flip-flops (s1, s2), then a third (s3); edge_o = s2 XOR s3, registered, so a data_i change sampled at edge k gives edge_o high for exactly the cycle after edge k+2.
REQ-013 SHALL sample clk_i_i in the cycle edge_o is high, with no delay compensation: clk_i_i=1 gives an early vote; clk_i_i=0 gives a late vote.
REQ-014 SHALL keep a signed filter counter fcnt in the range -FILT_N..+FILT_N: an early vote decrements, a late vote increments.
REQ-015 SHALL, on the vote that would take fcnt to -FILT_N, set fcnt to 0 and start a BEFORE command; on +FILT_N, set fcnt to 0 and start an AFTER command.
REQ-016 SHALL use an FSM with states IDLE, BEFORE and AFTER: IDLE goes to BEFORE or AFTER per REQ-015; the command state lasts exactly CMD_LEN cycles, then returns to IDLE.
REQ-017 SHALL drive pd_before_o high only in BEFORE and pd_after_o high only in AFTER; the two are never high together, and the first high cycle is the cycle after the threshold vote.
REQ-018 SHALL, while in BEFORE or AFTER, discard votes, leaving fcnt unchanged, and still assert edge_o.
REQ-019 SHALL use a saturating lock counter lcnt: it increments on each edge_o cycle in which no command starts, and clears to 0 when a command starts.
REQ-020 SHALL register lock_o high while lcnt >= LOCK_CNT; lock_o falls the cycle after lcnt clears.
REQ-021 SHALL size fcnt, the CMD_LEN counter and lcnt from the parameters with $clog2, with no wrap at any boundary.
REQ-022 SHALL, with no data transitions, hold fcnt and lcnt and leave every output low except lock_o.

Reset
REQ-023 SHALL, on rst_i high at a clk32_i edge, clear s1, s2, s3, fcnt, lcnt and the command counter, put the FSM in IDLE, and drive all outputs to 0.
REQ-024 SHALL, if rst_i asserts mid-command, drop pd_before_o/pd_after_o low at that same clock edge with no completion of CMD_LEN.
REQ-025 SHALL, for the first edge after reset release, take s3 as 0, so data_i=1 at release yields one edge_o.

Structure
REQ-026 SHALL place the FILT_N, CMD_LEN and LOCK_CNT defaults and the FSM state encoding (IDLE=2'd0, BEFORE=2'd1, AFTER=2'd2) in shared package dpll_pkg.
REQ-027 SHALL implement the synchronizer and edge detector (REQ-012) as sub-module data_sync_edge, instantiated once.

Verification
REQ-028 SHALL cover: reset, then data_i toggled 8 times with clk_i_i=1 at each edge_o -> pd_before_o high for exactly 2 cycles starting the cycle after the 8th edge_o; pd_after_o stays 0.
REQ-029 SHALL cover: 7 late votes then 7 early votes -> no command, fcnt returns to 0, lcnt=14.
REQ-030 SHALL cover: an 8th late vote, then a 9th edge during the AFTER window -> a single 2-cycle pd_after_o; the 9th vote is discarded, so fcnt=0 afterwards.
REQ-031 SHALL cover: 64 alternating-vote edges with no command -> lock_o rises after the 64th edge_o; 8 further early votes -> lock_o falls the cycle after pd_before_o rises.
REQ-032 SHALL cover: rst_i pulsed in the 1st cycle of BEFORE -> both pd outputs are 0 at that edge and fcnt=0, lcnt=0, lock_o=0.
REQ-033 SHALL cover: data_i held static for 1000 cycles -> edge_o and both pd outputs stay 0, and lock_o holds its previous value.

Source files
------------

// File: rtl/dpll_pkg.sv
// Shared defaults and FSM state encoding for the DPLL phase detector.
package dpll_pkg;

    // Default parameter values for dpll_phase_detect.
    localparam int FILT_N_DEF   = 8;
    localparam int CMD_LEN_DEF  = 2;
    localparam int LOCK_CNT_DEF = 64;

    // Command FSM encoding; kept as plain constants so older tools and
    // scripts that decode the raw state bits keep working.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_BEFORE = 2'd1;
    localparam state_t ST_AFTER  = 2'd2;

endpackage

// File: rtl/data_sync_edge.sv
// Two-flop synchronizer for the asynchronous data stream, plus a third
// stage and a registered XOR that marks every data transition with a
// single-cycle strobe.
module data_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic data,
    output logic strobe
);

    logic s1;
    logic s2;
    logic s3;

    // Synchronize data, delay one more stage and flag any change between s2 and s3.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            s3     <= 1'b0;
            strobe <= 1'b0;
        end else begin
            s1     <= data;
            s2     <= s1;
            s3     <= s2;
            strobe <= s2 ^ s3;
        end
    end

endmodule

// File: rtl/dpll_phase_detect.sv
// Early/late phase detector for a DPSK bit-clock DPLL. Each data
// transition casts a vote based on the recovered clock level; a
// random-walk filter turns a run of one-sided votes into a fixed-length
// delete/add pulse command to the controlled divider. A lock counter
// tracks how many data edges have passed without a correction.
//
// Debug visibility: state, fcnt, cmd_cnt and lcnt are plain named
// registers at the top level so checkers can bind to them directly.
module dpll_phase_detect
    import dpll_pkg::*;
#(
    parameter int FILT_N   = FILT_N_DEF,
    parameter int CMD_LEN  = CMD_LEN_DEF,
    parameter int LOCK_CNT = LOCK_CNT_DEF
) (
    input  logic clk32_i,
    input  logic rst_i,
    input  logic data_i,
    input  logic clk_i_i,
    output logic pd_before_o,
    output logic pd_after_o,
    output logic edge_o,
    output logic lock_o
);

    // One extra bit so both -FILT_N and +FILT_N are representable.
    localparam int FW = $clog2(FILT_N + 1) + 1;
    localparam int CW = $clog2(CMD_LEN + 1);
    localparam int LW = $clog2(LOCK_CNT + 1);

    localparam logic signed [FW-1:0] F_ONE = FW'(1);
    localparam logic signed [FW-1:0] F_HI  = FW'(FILT_N);
    localparam logic signed [FW-1:0] F_LO  = -F_HI;
    localparam logic [CW-1:0]        CMD_LAST = CW'(CMD_LEN - 1);
    localparam logic [LW-1:0]        LOCK_MAX = LW'(LOCK_CNT);

    state_t                state;
    logic signed [FW-1:0]  fcnt;
    logic [CW-1:0]         cmd_cnt;
    logic [LW-1:0]         lcnt;

    logic vote;
    logic start_before;
    logic start_after;
    logic cmd_start;

    data_sync_edge u_sync (
        .clk    (clk32_i),
        .rst    (rst_i),
        .data   (data_i),
        .strobe (edge_o)
    );

    // Votes only count while idle; the threshold vote starts a command instead of reaching +/-FILT_N.
    always_comb begin
        vote         = edge_o && (state == ST_IDLE);
        start_before = vote &&  clk_i_i && (fcnt == F_LO + F_ONE);
        start_after  = vote && !clk_i_i && (fcnt == F_HI - F_ONE);
        cmd_start    = start_before || start_after;
    end

    // Random-walk filter: early votes step down, late votes step up, recentre when a command fires.
    always_ff @(posedge clk32_i) begin
        if (rst_i) begin
            fcnt <= '0;
        end else if (cmd_start) begin
            fcnt <= '0;
        end else if (vote) begin
            fcnt <= clk_i_i ? (fcnt - F_ONE) : (fcnt + F_ONE);
        end
    end

    // Command FSM: hold BEFORE/AFTER for exactly CMD_LEN cycles, then return to IDLE.
    always_ff @(posedge clk32_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            cmd_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cmd_cnt <= '0;
                    if (start_before) begin
                        state <= ST_BEFORE;
                    end else if (start_after) begin
                        state <= ST_AFTER;
                    end
                end
                ST_BEFORE, ST_AFTER: begin
                    if (cmd_cnt == CMD_LAST) begin
                        state   <= ST_IDLE;
                        cmd_cnt <= '0;
                    end else begin
                        cmd_cnt <= cmd_cnt + CW'(1);
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    cmd_cnt <= '0;
                end
            endcase
        end
    end

    // Lock counter: saturating count of data edges that did not trigger a correction.
    always_ff @(posedge clk32_i) begin
        if (rst_i) begin
            lcnt <= '0;
        end else if (cmd_start) begin
            lcnt <= '0;
        end else if (edge_o && (lcnt != LOCK_MAX)) begin
            lcnt <= lcnt + LW'(1);
        end
    end

    // Registered lock flag, one cycle behind the lock counter.
    always_ff @(posedge clk32_i) begin
        if (rst_i) begin
            lock_o <= 1'b0;
        end else begin
            lock_o <= (lcnt >= LOCK_MAX);
        end
    end

    // Divider commands decode straight from the FSM register, so they can never overlap.
    always_comb begin
        pd_before_o = (state == ST_BEFORE);
        pd_after_o  = (state == ST_AFTER);
    end

endmodule

// File: tb/tb_dpll_phase_detect.sv
// Testbench for dpll_phase_detect: a driver toggles data with a chosen
// recovered-clock level, pushing the expected command for each edge into
// a queue; a negedge monitor pops one entry per edge strobe and checks the
// exact pd_before/pd_after windows every cycle.
module tb_dpll_phase_detect;
    import dpll_pkg::*;

    localparam int FILT_N   = FILT_N_DEF;
    localparam int CMD_LEN  = CMD_LEN_DEF;
    localparam int LOCK_CNT = LOCK_CNT_DEF;

    localparam logic [1:0] CMD_NONE   = 2'd0;
    localparam logic [1:0] CMD_BEFORE = 2'd1;
    localparam logic [1:0] CMD_AFTER  = 2'd2;

    // ---------------- clock / reset ----------------
    logic clk32_i = 1'b0;
    logic rst_i   = 1'b1;
    logic data_i  = 1'b0;
    logic clk_i_i = 1'b0;
    logic pd_before_o;
    logic pd_after_o;
    logic edge_o;
    logic lock_o;

    always #5 clk32_i = ~clk32_i;

    dpll_phase_detect #(
        .FILT_N   (FILT_N),
        .CMD_LEN  (CMD_LEN),
        .LOCK_CNT (LOCK_CNT)
    ) dut (
        .clk32_i     (clk32_i),
        .rst_i       (rst_i),
        .data_i      (data_i),
        .clk_i_i     (clk_i_i),
        .pd_before_o (pd_before_o),
        .pd_after_o  (pd_after_o),
        .edge_o      (edge_o),
        .lock_o      (lock_o)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [1:0] exp_q[$];
    int mon_left      = 0;
    logic [1:0] mon_kind = CMD_NONE;
    int before_cycles = 0;
    int after_cycles  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, $signed(got), $signed(exp));
        end
    endtask

    function automatic int fcnt_now();
        return int'(dut.fcnt);
    endfunction

    function automatic int lcnt_now();
        return int'(dut.lcnt);
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk32_i) begin : monitor
        logic [1:0] c;
        check("pd_before", {31'd0, pd_before_o}, {31'd0, (mon_left > 0) && (mon_kind == CMD_BEFORE)});
        check("pd_after",  {31'd0, pd_after_o},  {31'd0, (mon_left > 0) && (mon_kind == CMD_AFTER)});
        if (pd_before_o) before_cycles++;
        if (pd_after_o)  after_cycles++;
        if (mon_left > 0) mon_left--;
        if (exp_q.size() == 0) begin
            check("spurious_edge", {31'd0, edge_o}, 32'd0);
        end else if (edge_o) begin
            c = exp_q.pop_front();
            if (c != CMD_NONE) begin
                mon_kind = c;
                mon_left = CMD_LEN;
            end
        end
        if (rst_i) begin
            mon_left = 0;
            exp_q.delete();
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk32_i);
        #1;
    endtask

    task automatic do_reset(input logic d);
        rst_i   = 1'b1;
        data_i  = d;
        clk_i_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic toggle(input logic v, input logic [1:0] cmd);
        clk_i_i = v;
        data_i  = ~data_i;
        exp_q.push_back(cmd);
    endtask

    task automatic wait_drain();
        logic ok;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk32_i);
        #1;
        ok = (exp_q.size() == 0);
        check("edge_seen", {31'd0, ok}, 32'd1);
        if (!ok) exp_q.delete();
    endtask

    task automatic send(input logic v, input logic [1:0] cmd);
        toggle(v, cmd);
        wait_drain();
        repeat ($urandom_range(0, 3)) tick();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int b0;
        int a0;

        // Reset values
        do_reset(1'b0);
        tick();
        check("rst_pd_before", {31'd0, pd_before_o}, 32'd0);
        check("rst_pd_after",  {31'd0, pd_after_o},  32'd0);
        check("rst_edge",      {31'd0, edge_o},      32'd0);
        check("rst_lock",      {31'd0, lock_o},      32'd0);
        check("rst_fcnt",      fcnt_now(),           32'd0);
        check("rst_lcnt",      lcnt_now(),           32'd0);

        // Eight early votes: one BEFORE command of CMD_LEN cycles, no AFTER
        b0 = before_cycles;
        a0 = after_cycles;
        for (int i = 0; i < FILT_N - 1; i++) send(1'b1, CMD_NONE);
        check("early7_fcnt", fcnt_now(), -(FILT_N - 1));
        send(1'b1, CMD_BEFORE);
        repeat (CMD_LEN + 3) tick();
        check("early8_before_len", before_cycles - b0, CMD_LEN);
        check("early8_after_len",  after_cycles - a0,  32'd0);
        check("early8_fcnt",       fcnt_now(),         32'd0);
        check("early8_lcnt",       lcnt_now(),         32'd0);

        // Seven late then seven early: walk returns to zero with no command
        do_reset(1'b0);
        b0 = before_cycles;
        a0 = after_cycles;
        for (int i = 0; i < 7; i++) send(1'b0, CMD_NONE);
        check("late7_fcnt", fcnt_now(), 32'd7);
        for (int i = 0; i < 7; i++) send(1'b1, CMD_NONE);
        check("walk_fcnt", fcnt_now(), 32'd0);
        check("walk_lcnt", lcnt_now(), 32'd14);
        check("walk_cmds", (before_cycles - b0) + (after_cycles - a0), 32'd0);

        // Eighth late vote fires AFTER; a ninth edge inside the window is discarded
        do_reset(1'b0);
        a0 = after_cycles;
        b0 = before_cycles;
        for (int i = 0; i < 7; i++) send(1'b0, CMD_NONE);
        toggle(1'b0, CMD_AFTER);
        tick();
        data_i = ~data_i;
        exp_q.push_back(CMD_NONE);
        tick();
        tick();
        tick();
        clk_i_i = 1'b1;
        wait_drain();
        repeat (CMD_LEN + 3) tick();
        check("after_len",    after_cycles - a0,  CMD_LEN);
        check("after_before", before_cycles - b0, 32'd0);
        check("after_fcnt",   fcnt_now(),         32'd0);
        check("after_lcnt",   lcnt_now(),         32'd1);

        // Alternating votes build lock
        do_reset(1'b0);
        for (int i = 0; i < LOCK_CNT - 1; i++) send((i % 2) == 0, CMD_NONE);
        check("lock_before_63", {31'd0, lock_o}, 32'd0);
        toggle(1'b0, CMD_NONE);
        wait_drain();
        @(negedge clk32_i);
        check("lock_edge64_n1", {31'd0, lock_o}, 32'd0);
        @(negedge clk32_i);
        check("lock_edge64_n2", {31'd0, lock_o}, 32'd1);
        tick();

        // Static data: nothing moves, lock holds
        for (int blk = 0; blk < 10; blk++) begin
            repeat (100) tick();
            check("static_lock", {31'd0, lock_o}, 32'd1);
        end
        check("static_fcnt", fcnt_now(), 32'd0);
        check("static_lcnt", lcnt_now(), LOCK_CNT);

        // Early votes saturate lcnt, then the command drops lock
        for (int i = 0; i < FILT_N - 1; i++) send(1'b1, CMD_NONE);
        check("sat_lcnt", lcnt_now(), LOCK_CNT);
        check("sat_lock", {31'd0, lock_o}, 32'd1);
        toggle(1'b1, CMD_BEFORE);
        wait_drain();
        @(negedge clk32_i);
        check("unlock_pd_before", {31'd0, pd_before_o}, 32'd1);
        check("unlock_lock_n1",   {31'd0, lock_o},      32'd1);
        @(negedge clk32_i);
        check("unlock_lock_n2",   {31'd0, lock_o},      32'd0);
        repeat (CMD_LEN + 2) tick();

        // Reset during the first BEFORE cycle aborts the command
        do_reset(1'b0);
        for (int i = 0; i < FILT_N - 1; i++) send(1'b1, CMD_NONE);
        toggle(1'b1, CMD_BEFORE);
        wait_drain();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        @(negedge clk32_i);
        check("midrst_pd_before", {31'd0, pd_before_o}, 32'd0);
        check("midrst_pd_after",  {31'd0, pd_after_o},  32'd0);
        check("midrst_lock",      {31'd0, lock_o},      32'd0);
        check("midrst_fcnt",      fcnt_now(),           32'd0);
        check("midrst_lcnt",      lcnt_now(),           32'd0);
        repeat (CMD_LEN + 3) tick();

        // data_i high across reset release gives exactly one edge
        do_reset(1'b1);
        clk_i_i = 1'b1;
        exp_q.push_back(CMD_NONE);
        wait_drain();
        repeat (10) tick();
        check("rel_fcnt", fcnt_now(), -1);
        check("rel_lcnt", lcnt_now(), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
